// File: rtl/sdio_flag_bank_if.sv
// Byte-wide register access bus for the SDIO flag bank.
// The host side drives strobes, address and write data; the bank returns registered read data.
interface sdio_flag_bank_if;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;

    modport master (
        output reg_wr,
        output reg_rd,
        output reg_addr,
        output reg_wdata,
        input  reg_rdata
    );

    modport slave (
        input  reg_wr,
        input  reg_rd,
        input  reg_addr,
        input  reg_wdata,
        output reg_rdata
    );
endinterface

// File: rtl/sdio_flag_bank.sv
// Sticky interrupt/error flag bank for the SDIO host: up to 16 event-set flags
// with status/signal enables, overflow tracking, group clears, byte-wide
// register access and a registered interrupt request.
module sdio_flag_bank #(
    parameter int unsigned NUM_FLAGS      = 11,
    parameter logic [7:0]  REG_ADDR_STS    = 8'd32,
    parameter logic [7:0]  REG_ADDR_STS_EN = 8'd34,
    parameter logic [7:0]  REG_ADDR_SIG_EN = 8'd36,
    parameter logic [7:0]  REG_ADDR_OVF    = 8'd38,
    parameter logic [15:0] CMD_GRP_MASK    = 16'h0000,
    parameter logic [15:0] DAT_GRP_MASK    = 16'h0000,
    parameter logic [15:0] START_CLR_MASK  = 16'hFFFF,
    parameter logic [15:0] STS_EN_RST      = 16'hFFFF,
    parameter logic [15:0] SIG_EN_RST      = 16'h0000
) (
    input  logic                 sd_clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_sd_rst_i,
    input  logic                 dat_sd_rst_i,
    input  logic                 all_sd_rst_i,
    input  logic                 cmd_start_i,
    sdio_flag_bank_if.slave      bus,
    input  logic [NUM_FLAGS-1:0] event_i,
    output logic [NUM_FLAGS-1:0] flag_o,
    output logic [NUM_FLAGS-1:0] ovf_o,
    output logic                 irq_o
);

    // Bits at NUM_FLAGS and above are never stored, so they read back as 0.
    localparam logic [15:0] VALID  = (NUM_FLAGS >= 16) ? 16'hFFFF
                                   : 16'((32'd1 << NUM_FLAGS) - 32'd1);
    localparam bit          HAS_HI = (NUM_FLAGS > 8);

    logic [15:0] flag_q, flag_d;
    logic [15:0] ovf_q, ovf_d;
    logic [15:0] sts_en_q, sts_en_d;
    logic [15:0] sig_en_q, sig_en_d;
    logic        irq_q, irq_d;
    logic [7:0]  rdata_q, rdata_d;

    logic [15:0] ev16;
    logic [15:0] wdata16;
    logic [15:0] grp_clr;
    logic [15:0] set_v;
    logic [15:0] wr_sts, wr_ovf, wr_sts_en, wr_sig_en;

    // Bit lanes covered by a byte access at addr to the 16-bit register at base.
    function automatic logic [15:0] lane(input logic [7:0] addr, input logic [7:0] base);
        logic [15:0] m;
        m = '0;
        if (addr == base)
            m[7:0] = '1;
        if (HAS_HI && (addr == base + 8'd1))
            m[15:8] = '1;
        return m & VALID;
    endfunction

    // Byte of a 16-bit register selected by addr, or 0 when addr misses it.
    function automatic logic [7:0] byte_of(input logic [15:0] word, input logic [7:0] addr,
                                           input logic [7:0] base);
        if (addr == base)
            return word[7:0];
        else if (addr == base + 8'd1)
            return word[15:8];
        else
            return '0;
    endfunction

    // Write decode, group clears and next-state for every stored register.
    always_comb begin
        ev16                  = '0;
        ev16[NUM_FLAGS-1:0]   = event_i;
        wdata16               = {bus.reg_wdata, bus.reg_wdata};

        wr_sts    = bus.reg_wr ? lane(bus.reg_addr, REG_ADDR_STS)    : '0;
        wr_ovf    = bus.reg_wr ? lane(bus.reg_addr, REG_ADDR_OVF)    : '0;
        wr_sts_en = bus.reg_wr ? lane(bus.reg_addr, REG_ADDR_STS_EN) : '0;
        wr_sig_en = bus.reg_wr ? lane(bus.reg_addr, REG_ADDR_SIG_EN) : '0;

        grp_clr = {16{all_sd_rst_i}}
                | ({16{cmd_sd_rst_i}} & CMD_GRP_MASK)
                | ({16{dat_sd_rst_i}} & DAT_GRP_MASK)
                | ({16{cmd_start_i}}  & START_CLR_MASK);

        set_v = ev16 & sts_en_q & VALID;

        // Group clear beats event set, which beats the W1C write.
        flag_d = ((flag_q & ~(wr_sts & wdata16)) | set_v) & ~grp_clr & VALID;
        ovf_d  = ((ovf_q & ~(wr_ovf & wdata16)) | (set_v & flag_q)) & ~grp_clr & VALID;

        sts_en_d = ((sts_en_q & ~wr_sts_en) | (wdata16 & wr_sts_en)) & VALID;
        sig_en_d = ((sig_en_q & ~wr_sig_en) | (wdata16 & wr_sig_en)) & VALID;

        irq_d = |(flag_q & sig_en_q);

        rdata_d = rdata_q;
        if (bus.reg_rd)
            rdata_d = byte_of(flag_q,   bus.reg_addr, REG_ADDR_STS)
                    | byte_of(sts_en_q, bus.reg_addr, REG_ADDR_STS_EN)
                    | byte_of(sig_en_q, bus.reg_addr, REG_ADDR_SIG_EN)
                    | byte_of(ovf_q,    bus.reg_addr, REG_ADDR_OVF);
    end

    // State registers; reset overrides every event and strobe in its cycle.
    always_ff @(posedge sd_clk_i) begin
        if (rst_i) begin
            flag_q   <= '0;
            ovf_q    <= '0;
            sts_en_q <= STS_EN_RST & VALID;
            sig_en_q <= SIG_EN_RST & VALID;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            flag_q   <= flag_d;
            ovf_q    <= ovf_d;
            sts_en_q <= sts_en_d;
            sig_en_q <= sig_en_d;
            irq_q    <= irq_d;
            rdata_q  <= rdata_d;
        end
    end

    assign flag_o        = flag_q[NUM_FLAGS-1:0];
    assign ovf_o         = ovf_q[NUM_FLAGS-1:0];
    assign irq_o         = irq_q;
    assign bus.reg_rdata = rdata_q;

endmodule

// File: tb/tb_sdio_flag_bank.sv
// Self-checking bench for sdio_flag_bank: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a per-flag rule model.
module tb_sdio_flag_bank;

    localparam int unsigned NF      = 11;
    localparam logic [15:0] CMD_M   = 16'h000F;
    localparam logic [15:0] DAT_M   = 16'h0070;
    localparam logic [15:0] START_M = 16'hFFFF;
    localparam logic [15:0] STS_RST = 16'hFFFF;
    localparam logic [15:0] SIG_RST = 16'h0000;

    typedef logic [NF-1:0] flags_t;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    logic   cmd_rst = 1'b0, dat_rst = 1'b0, all_rst = 1'b0, cmd_start = 1'b0;
    flags_t ev = '0;
    flags_t flag, ovf;
    logic   irq;

    sdio_flag_bank_if bus_if ();

    sdio_flag_bank #(
        .NUM_FLAGS    (NF),
        .CMD_GRP_MASK (CMD_M),
        .DAT_GRP_MASK (DAT_M)
    ) dut (
        .sd_clk_i     (clk),
        .rst_i        (rst),
        .cmd_sd_rst_i (cmd_rst),
        .dat_sd_rst_i (dat_rst),
        .all_sd_rst_i (all_rst),
        .cmd_start_i  (cmd_start),
        .bus          (bus_if),
        .event_i      (ev),
        .flag_o       (flag),
        .ovf_o        (ovf),
        .irq_o        (irq)
    );

    always #5 clk = ~clk;

    // Reference state, one 16-bit word per register; non-existent bits kept 0.
    logic [15:0] m_flag, m_ovf, m_sts, m_sig;
    logic        m_irq;
    logic [7:0]  m_rdata;
    logic [15:0] m_valid;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Register map: 32..39 hold STS, STS_EN, SIG_EN, OVF as low/high byte pairs.
    function automatic logic [7:0] read_model(input logic [7:0] addr);
        logic [15:0] w;
        int unsigned off;
        if (addr < 8'd32 || addr > 8'd39)
            return 8'h00;
        off = int'(addr) - 32;
        case (off / 2)
            0:       w = m_flag;
            1:       w = m_sts;
            2:       w = m_sig;
            default: w = m_ovf;
        endcase
        return (off % 2 == 1) ? w[15:8] : w[7:0];
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        logic [15:0] f_n, o_n, s_n, g_n, ev16;
        logic [15:0] cmv, dmv, smv;
        logic        gc, wb, wr;
        logic [7:0]  addr;
        int unsigned ln;
        if (rst) begin
            m_flag  = '0;
            m_ovf   = '0;
            m_sts   = STS_RST & m_valid;
            m_sig   = SIG_RST & m_valid;
            m_irq   = 1'b0;
            m_rdata = '0;
            return;
        end
        cmv  = CMD_M;
        dmv  = DAT_M;
        smv  = START_M;
        ev16 = '0;
        ev16[NF-1:0] = ev;
        wr   = bus_if.reg_wr;
        addr = bus_if.reg_addr;
        f_n  = m_flag;
        o_n  = m_ovf;
        s_n  = m_sts;
        g_n  = m_sig;
        for (int unsigned i = 0; i < NF; i++) begin
            ln = i / 8;
            wb = bus_if.reg_wdata[i % 8];
            gc = all_rst | (cmd_rst & cmv[i]) | (dat_rst & dmv[i]) | (cmd_start & smv[i]);
            if (gc)
                f_n[i] = 1'b0;
            else if (ev16[i] && m_sts[i])
                f_n[i] = 1'b1;
            else if (wr && addr == 8'(32 + ln) && wb)
                f_n[i] = 1'b0;
            if (gc)
                o_n[i] = 1'b0;
            else if (ev16[i] && m_sts[i] && m_flag[i])
                o_n[i] = 1'b1;
            else if (wr && addr == 8'(38 + ln) && wb)
                o_n[i] = 1'b0;
            if (wr && addr == 8'(34 + ln))
                s_n[i] = wb;
            if (wr && addr == 8'(36 + ln))
                g_n[i] = wb;
        end
        if (bus_if.reg_rd)
            m_rdata = read_model(addr);
        m_irq  = |(m_flag & m_sig);
        m_flag = f_n;
        m_ovf  = o_n;
        m_sts  = s_n;
        m_sig  = g_n;
    endtask

    // One clock: model update, edge, compare all outputs, drop the pulses.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("flag",  32'(flag),  32'(m_flag[NF-1:0]));
        check("ovf",   32'(ovf),   32'(m_ovf[NF-1:0]));
        check("irq",   32'(irq),   32'(m_irq));
        check("rdata", 32'(bus_if.reg_rdata), 32'(m_rdata));
        rst = 1'b0; cmd_rst = 1'b0; dat_rst = 1'b0; all_rst = 1'b0; cmd_start = 1'b0;
        ev = '0;
        bus_if.reg_wr = 1'b0;
        bus_if.reg_rd = 1'b0;
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        bus_if.reg_wr    = 1'b1;
        bus_if.reg_addr  = a;
        bus_if.reg_wdata = d;
        tick();
    endtask

    task automatic rd_reg(input logic [7:0] a);
        bus_if.reg_rd   = 1'b1;
        bus_if.reg_addr = a;
        tick();
    endtask

    initial begin
        m_valid = 16'((32'd1 << NF) - 32'd1);
        m_flag = '0; m_ovf = '0; m_sts = '0; m_sig = '0; m_irq = 1'b0; m_rdata = '0;
        bus_if.reg_wr = 1'b0; bus_if.reg_rd = 1'b0;
        bus_if.reg_addr = '0; bus_if.reg_wdata = '0;

        // Reset and enable-register reset values.
        rst = 1'b1; tick();
        rst = 1'b1; tick();
        check("rst_flag", 32'(flag), 32'h0);
        check("rst_irq",  32'(irq),  32'h0);
        rd_reg(8'd34); check("rst_sts_en_lo", 32'(bus_if.reg_rdata), 32'hFF);
        rd_reg(8'd35); check("rst_sts_en_hi", 32'(bus_if.reg_rdata), 32'h07);
        rd_reg(8'd36); check("rst_sig_en_lo", 32'(bus_if.reg_rdata), 32'h00);

        // Event -> flag next cycle -> irq the cycle after; W1C clears with same latency.
        wr_reg(8'd36, 8'h01);
        ev = 11'h001; tick();
        check("ev0_flag", 32'(flag[0]), 32'h1);
        check("ev0_irq_lag", 32'(irq), 32'h0);
        tick();
        check("ev0_irq", 32'(irq), 32'h1);
        wr_reg(8'd32, 8'h01);
        check("w1c_flag", 32'(flag[0]), 32'h0);
        tick();
        check("w1c_irq", 32'(irq), 32'h0);

        // Event wins over simultaneous W1C; repeat event sets overflow.
        ev = 11'h004; wr_reg(8'd32, 8'h04);
        check("ev_vs_w1c", 32'(flag[2]), 32'h1);
        ev = 11'h004; tick();
        check("ovf2", 32'(ovf[2]), 32'h1);
        rd_reg(8'd38); check("rd_ovf_lo", 32'(bus_if.reg_rdata), 32'h04);

        // Group clears.
        ev = 11'h07F; tick();
        cmd_rst = 1'b1; tick();
        check("cmd_grp", 32'(flag[6:0]), 32'h70);
        all_rst = 1'b1; tick();
        check("all_grp", 32'(flag), 32'h0);
        rd_reg(8'd34); check("grp_sts_en", 32'(bus_if.reg_rdata), 32'hFF);
        rd_reg(8'd36); check("grp_sig_en", 32'(bus_if.reg_rdata), 32'h01);

        // Status-enable gating and unmapped high bits.
        wr_reg(8'd34, 8'hFE);
        ev = 11'h001; tick();
        check("sts_en_gate", 32'(flag[0]), 32'h0);
        wr_reg(8'd35, 8'hFF);
        rd_reg(8'd35); check("hi_bits_absent", 32'(bus_if.reg_rdata), 32'h07);

        // Reset overrides concurrent event and write.
        rst = 1'b1; ev = 11'h002; wr_reg(8'd36, 8'hFF);
        check("rst_ovr_flag", 32'(flag), 32'h0);
        check("rst_ovr_rdata", 32'(bus_if.reg_rdata), 32'h0);
        rd_reg(8'd36); check("rst_ovr_sig_en", 32'(bus_if.reg_rdata), 32'h00);
        rd_reg(8'd34); check("rst_ovr_sts_en", 32'(bus_if.reg_rdata), 32'hFF);

        // Randomized traffic against the model.
        wr_reg(8'd36, 8'hFF);
        wr_reg(8'd37, 8'hFF);
        for (int unsigned c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) < 45)
                ev = flags_t'($urandom & $urandom);
            if ($urandom_range(0, 99) < 30) begin
                bus_if.reg_wr    = 1'b1;
                bus_if.reg_wdata = 8'($urandom);
            end
            if ($urandom_range(0, 99) < 45)
                bus_if.reg_rd = 1'b1;
            bus_if.reg_addr = 8'($urandom_range(29, 41));
            cmd_rst   = ($urandom_range(0, 99) < 3);
            dat_rst   = ($urandom_range(0, 99) < 3);
            all_rst   = ($urandom_range(0, 99) < 2);
            cmd_start = ($urandom_range(0, 99) < 3);
            rst       = ($urandom_range(0, 199) < 1);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
